// File: rtl/fetch_stage_if.sv
// Interface bundling the fetch stage's memory request/response, redirect and
// decode-facing buses. The master modport is the fetch stage's view; the
// slave modport is the view of the surrounding memory/execute/decode logic.
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [2:0]  out_f3;
  logic        out_f7;
  logic [24:0] out_imm_sample;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  resp_valid, resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, out_opcode, out_f3, out_f7, out_imm_sample,
    input  out_ready
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output resp_valid, resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, out_opcode, out_f3, out_f7, out_imm_sample,
    output out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, issues in-order word fetches under a
// credit limit of DEPTH (in-flight requests plus buffered words), buffers the
// returned words in a DEPTH-entry FIFO and hands them to decode together with
// their PC and decoder field slices. A redirect flushes the FIFO, reloads the
// PCs and arranges for every response still in flight to be discarded.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic          issue;
  logic          resp_dec;
  logic          drop_now;
  logic          push;
  logic          pop;

  // Wrap a FIFO pointer at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Buffered words count against the credit as well as in-flight requests,
  // which is what keeps the FIFO from ever overflowing.
  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.req_valid = !rst && !bus.redirect_valid && (credit_used < {1'b0, DEPTH_C});
  assign bus.req_addr  = fetch_pc;

  assign issue    = bus.req_valid && bus.req_ready;
  assign resp_dec = bus.resp_valid && (outstanding != '0);
  assign drop_now = bus.resp_valid && (drop_cnt != '0);
  assign push     = bus.resp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop      = bus.out_valid && bus.out_ready;

  // PC bookkeeping and request/drop counters; a redirect reloads both PCs and
  // marks everything still in flight (minus a response landing now) as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp_dec);
      if (bus.redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= outstanding - CW'(resp_dec);
      end else begin
        if (issue)    fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        if (drop_now) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // FIFO occupancy and pointers; a redirect empties it regardless of any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (bus.redirect_valid) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= bus.resp_data;
    end
  end

  assign bus.out_valid      = (fifo_count != '0);
  assign bus.out_pc         = pc_mem[rd_ptr];
  assign bus.out_instr      = instr_mem[rd_ptr];
  assign bus.out_opcode     = instr_mem[rd_ptr][6:0];
  assign bus.out_f3         = instr_mem[rd_ptr][14:12];
  assign bus.out_f7         = instr_mem[rd_ptr][30];
  assign bus.out_imm_sample = instr_mem[rd_ptr][31:7];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_count == DEPTH_C));

  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.resp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. A memory model answers requests in order after a
// configurable latency, tagging each request with a redirect epoch; the
// reference model keeps the expected decode queue as a plain queue of
// {pc, word} and predicts req_valid from in-flight plus buffered counts.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          NV       = 6;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f7;
    logic [24:0] imm;
  } dec_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  mem_req_t    mq[$];
  fifo_ent_t   fq[$];
  logic [31:0] acc_log[$];
  logic [31:0] out_log[$];
  dec_vec_t    vecs[NV];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          mem_hold = 1'b0;
  logic [31:0] exp_fetch_pc = RESET_PC;

  logic        last_req_valid;
  logic        last_out_valid;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic [6:0]  last_opcode;
  logic [2:0]  last_f3;
  logic        last_f7;
  logic [24:0] last_imm;

  // Memory image: a small patch window for the decode vectors, a hash elsewhere.
  function automatic logic [31:0] word_for(input logic [31:0] addr);
    if (addr >= 32'h200 && addr < 32'h200 + 32'(4 * NV))
      return vecs[int'((addr - 32'h200) >> 2)].instr;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic ordy, input logic redir,
                                input logic [31:0] rpc, output logic resp_now);
    @(negedge clk);
    resp_now = !mem_hold && mq.size() != 0 && mq[0].due <= cyc;
    bus.req_ready      = rdy;
    bus.out_ready      = ordy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.resp_valid     = resp_now;
    bus.resp_data      = resp_now ? mq[0].data : $urandom();
  endtask

  task automatic check_output(input logic rdy, input logic ordy, input logic redir,
                              output logic exp_rv);
    #2;
    exp_rv = !redir && (mq.size() + fq.size() < DEPTH);
    check("req_valid", 32'(bus.req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", bus.req_addr, exp_fetch_pc);
    check("out_valid", 32'(bus.out_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      check("out_pc", bus.out_pc, fq[0].pc);
      check("out_instr", bus.out_instr, fq[0].instr);
      check("out_opcode", 32'(bus.out_opcode), 32'(fq[0].instr[6:0]));
      check("out_imm_sample", 32'(bus.out_imm_sample), 32'(fq[0].instr[31:7]));
    end
    last_req_valid = bus.req_valid;
    last_out_valid = bus.out_valid;
    last_pc        = bus.out_pc;
    last_instr     = bus.out_instr;
    last_opcode    = bus.out_opcode;
    last_f3        = bus.out_f3;
    last_f7        = bus.out_f7;
    last_imm       = bus.out_imm_sample;
    if (bus.req_valid && rdy) acc_log.push_back(bus.req_addr);
    if (bus.out_valid && ordy && !redir) out_log.push_back(bus.out_pc);
  endtask

  // Advance the reference model by one clock edge from the cycle's inputs.
  task automatic update_model(input logic rdy, input logic ordy, input logic redir,
                              input logic [31:0] rpc, input logic resp_now, input logic exp_rv);
    mem_req_t  m;
    fifo_ent_t f;
    if (redir) begin
      epoch++;
      fq.delete();
      exp_fetch_pc = rpc & 32'hFFFF_FFFC;
      if (resp_now) mq.delete(0);
    end else begin
      if (fq.size() != 0 && ordy) fq.delete(0);
      if (resp_now) begin
        m = mq[0];
        mq.delete(0);
        if (m.epoch == epoch) begin
          f.pc    = m.addr;
          f.instr = m.data;
          fq.push_back(f);
        end
      end
      if (exp_rv && rdy) begin
        m.addr  = exp_fetch_pc;
        m.data  = word_for(exp_fetch_pc);
        m.epoch = epoch;
        m.due   = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(m);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic run_cycle(input logic rdy, input logic ordy, input logic redir,
                           input logic [31:0] rpc);
    logic resp_now;
    logic exp_rv;
    apply_stimulus(rdy, ordy, redir, rpc, resp_now);
    check_output(rdy, ordy, redir, exp_rv);
    update_model(rdy, ordy, redir, rpc, resp_now, exp_rv);
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_ready      = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = 32'h0;
    mq.delete();
    fq.delete();
    epoch++;
    exp_fetch_pc = RESET_PC;
    repeat (2) begin
      #2;
      check("rst_req_valid", 32'(bus.req_valid), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    out_log.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    vecs[0] = '{32'h4000_D093, 7'h13, 3'h5, 1'b1, 25'h08001A1};
    vecs[1] = '{32'h0000_0013, 7'h13, 3'h0, 1'b0, 25'h0000000};
    vecs[2] = '{32'hFFFF_FFFF, 7'h7F, 3'h7, 1'b1, 25'h1FFFFFF};
    vecs[3] = '{32'h0020_8033, 7'h33, 3'h0, 1'b0, 25'h0004100};
    vecs[4] = '{32'h4000_0000, 7'h00, 3'h0, 1'b1, 25'h0800000};
    vecs[5] = '{32'h0000_7000, 7'h00, 3'h7, 1'b0, 25'h00000E0};

    bus.req_ready = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0; bus.resp_valid = 1'b0; bus.resp_data = 32'h0;

    // Streaming with 1-cycle memory and decode always ready.
    do_reset();
    clear_logs();
    repeat (24) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_issued_enough", 32'(acc_log.size() >= 8), 32'h1);
    check("t1_output_enough", 32'(out_log.size() >= 8), 32'h1);
    for (int i = 0; i < 8; i++) begin
      if (acc_log.size() > i) check("t1_req_addr_seq", acc_log[i], 32'(4 * i));
      if (out_log.size() > i) check("t1_out_pc_seq", out_log[i], 32'(4 * i));
    end

    // Decode stalled: credit caps issue, head stays put; then resume in order.
    do_reset();
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (i >= 4) begin
        check("t2_stall_valid", 32'(last_out_valid), 32'h1);
        check("t2_stall_pc", last_pc, RESET_PC);
        check("t2_stall_instr", last_instr, word_for(RESET_PC));
      end
    end
    check("t2_issued_during_stall", 32'(acc_log.size()), 32'(DEPTH));
    clear_logs();
    repeat (12) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t2_resume_enough", 32'(out_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      if (out_log.size() > i) check("t2_resume_pc", out_log[i], 32'(4 * i));

    // Two requests in flight when a redirect to a misaligned PC arrives.
    do_reset();
    mem_hold = 1'b1;
    run_cycle(1'b0, 1'b1, 1'b1, 32'h10);
    clear_logs();
    repeat (3) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_inflight_count", 32'(acc_log.size()), 32'h2);
    if (acc_log.size() == 2) begin
      check("t3_first_addr", acc_log[0], 32'h10);
      check("t3_second_addr", acc_log[1], 32'h14);
    end
    run_cycle(1'b0, 1'b1, 1'b1, 32'h103);
    mem_hold = 1'b0;
    clear_logs();
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_has_req", 32'(acc_log.size() != 0), 32'h1);
    check("t3_has_out", 32'(out_log.size() != 0), 32'h1);
    if (acc_log.size() != 0) check("t3_next_req_addr", acc_log[0], 32'h100);
    if (out_log.size() != 0) check("t3_first_out_pc", out_log[0], 32'h100);

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fq.size() != 0 && mq.size() != 0 && mq[0].due <= cyc) found = 1'b1;
      else run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check("t4_setup_reached", 32'(found), 32'h1);
    if (found) begin
      run_cycle(1'b1, 1'b1, 1'b1, 32'h300);
      check("t4_no_req_in_redirect", 32'(last_req_valid), 32'h0);
      clear_logs();
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("t4_fifo_empty_after", 32'(last_out_valid), 32'h0);
      repeat (6) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (out_log.size() != 0) check("t4_first_out_pc", out_log[0], 32'h300);
      else check("t4_first_out_pc", 32'hFFFF_FFFF, 32'h300);
    end

    // Redirect to the last word of the address space; fetch must wrap to 0.
    do_reset();
    run_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    clear_logs();
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_enough", 32'(acc_log.size() >= 2 && out_log.size() >= 2), 32'h1);
    if (acc_log.size() >= 2) begin
      check("t5_req_top", acc_log[0], 32'hFFFF_FFFC);
      check("t5_req_wrap", acc_log[1], 32'h0000_0000);
    end
    if (out_log.size() >= 2) begin
      check("t5_out_top", out_log[0], 32'hFFFF_FFFC);
      check("t5_out_wrap", out_log[1], 32'h0000_0000);
    end

    // Decoder field slices from the vector table.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4 * i));
      for (int k = 0; k < 8; k++) begin
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        if (last_out_valid) break;
      end
      check("t6_valid", 32'(last_out_valid), 32'h1);
      check("t6_pc", last_pc, 32'h200 + 32'(4 * i));
      check("t6_instr", last_instr, vecs[i].instr);
      check("t6_opcode", 32'(last_opcode), 32'(vecs[i].opcode));
      check("t6_f3", 32'(last_f3), 32'(vecs[i].f3));
      check("t6_f7", 32'(last_f7), 32'(vecs[i].f7));
      check("t6_imm_sample", 32'(last_imm), 32'(vecs[i].imm));
    end

    // Random traffic, random latency, random redirects and a mid-run reset.
    do_reset();
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
